// File: rtl/binary2bcd.sv
// Sequential binary-to-BCD converter (double-dabble). One iteration per clock;
// a start in IDLE launches BIN_W iterations, then done pulses with the result.
module binary2bcd #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    binary,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow
);

  localparam int BCD_W   = 4 * DIGITS;
  localparam int SR_W    = BCD_W + BIN_W;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int MAX_VAL = (10 ** DIGITS) - 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovp_q, ovp_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [BCD_W-1:0]   adj;
  logic [SR_W-1:0]    shifted;
  logic [BCD_W-1:0]   all_nines;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      // Add 3 to any digit >= 5 so the following shift carries correctly into the next digit.
      assign adj[4*gi +: 4] = (sr_q[BIN_W + 4*gi +: 4] >= 4'd5)
                              ? sr_q[BIN_W + 4*gi +: 4] + 4'd3
                              : sr_q[BIN_W + 4*gi +: 4];
      assign all_nines[4*gi +: 4] = 4'h9;
    end
  endgenerate

  assign shifted = {adj[BCD_W-2:0], sr_q[BIN_W-1:0], 1'b0};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ovp_d   = ovp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, binary};
          cnt_d   = CNT_W'(BIN_W);
          ovp_d   = (32'(binary) > MAX_VAL);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = shifted;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = ovp_q ? all_nines : shifted[SR_W-1:BIN_W];
          ovf_d   = ovp_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ovp_q   <= ovp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_binary2bcd.sv
// Scoreboard bench for binary2bcd: arithmetic reference model, queued expectations,
// independent monitor checking result, overflow, latency and busy.
module tb_binary2bcd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] binary = '0;
  logic        busy, done, overflow;
  logic [15:0] bcd;

  binary2bcd #(.BIN_W(14), .DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .binary(binary),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          due;
    int          val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_edge = 0;
  bit   active = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal digits by plain division, saturating at 9999.
  function automatic exp_t model(int v);
    exp_t e;
    int t;
    t = (v > 9999) ? 9999 : v;
    e.bcd = {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
    e.ovf = (v > 9999);
    e.val = v;
    e.due = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (edge cyc+1).
  task automatic issue(input int v);
    exp_t e;
    int   edge_n;
    edge_n = cyc + 1;
    start  = 1'b1;
    binary = 14'(v);
    if (!active || edge_n >= acc_edge + 15) begin
      e = model(v);
      e.due = edge_n + 14;
      sb.push_back(e);
      acc_edge = edge_n;
      active = 1;
    end
    @(negedge clk);
    start  = 1'b0;
    binary = 14'($urandom);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL done_timeout: got no done within 40 cycles, expected done");
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(active && cyc >= acc_edge && cyc < acc_edge + 14));
      if (done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 bcd=%h, expected no done", bcd);
        end else begin
          e = sb.pop_front();
          chk($sformatf("bcd(%0d)", e.val), 32'(bcd), 32'(e.bcd));
          chk($sformatf("overflow(%0d)", e.val), 32'(overflow), 32'(e.ovf));
          chk($sformatf("latency(%0d)", e.val), 32'(cyc), 32'(e.due));
          $display("[TB] conv %0d -> bcd=%h ovf=%0b at cycle %0d", e.val, bcd, overflow, cyc);
        end
      end
    end
  end

  int directed[] = '{0, 10, 15, 20, 100, 125, 150, 175, 200, 210, 255,
                     1150, 1175, 1200, 1210, 1255, 9999, 10000, 16383};

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bcd", 32'(bcd), 0);
    chk("rst_ovf", 32'(overflow), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-conversion aborts without a done
    issue(1234);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    active = 0;
    sb.delete();
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_bcd", 32'(bcd), 0);
    chk("abort_ovf", 32'(overflow), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    foreach (directed[i]) begin
      issue(directed[i]);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // start while busy is ignored; start in the done cycle is accepted
    issue(42);
    repeat (2) @(negedge clk);
    issue(77);
    wait_done();
    issue(77);
    wait_done();

    // Randomized, with stray starts while busy and back-to-back restarts
    for (int n = 0; n < 40; n++) begin
      issue(int'($urandom_range(0, 16383)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 8)) @(negedge clk);
        issue(int'($urandom_range(0, 16383)));
      end
      wait_done();
      if ($urandom_range(0, 1) == 1) begin
        issue(int'($urandom_range(0, 16383)));
        wait_done();
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending results, expected 0", sb.size());
    end
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/binary2bcd.md
Name:
binary2bcd

Overview:
- Sequential binary-to-BCD converter using the double-dabble (shift-add-3) algorithm.
- Takes a 14-bit unsigned binary value and produces a 4-digit packed BCD result (thousands, hundreds, tens, units).
- Sits between the calculator arithmetic core and the 7-segment/display driver.
- Uses a start/done handshake; one conversion runs at a time.

Parameters:
- BIN_W, 14, width of the binary input.
- DIGITS, 4, number of BCD output digits. bcd width = 4*DIGITS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion. Sampled on a rising edge while busy=0.
- binary  input  14  unsigned operand. Captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when bcd/overflow are updated.
- bcd  output  16  packed BCD result: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- overflow  output  1  set with done when the captured binary value exceeds 9999.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - busy=0, done=0, bcd=16'h0000, overflow=0.
  - Internal shift register and counter cleared; FSM goes to IDLE.
  - Asserting reset mid-conversion aborts it; no done is produced.
- States: IDLE, SHIFT.
- IDLE:
  - On an edge with start=1: capture binary, load the shift register {16'b0, binary}, set the iteration counter to 14, set busy=1, go to SHIFT.
  - Capture overflow_pending = (binary > 9999).
- SHIFT, each edge performs one iteration:
  - First, every BCD nibble ≥5 gets +3.
  - Then the whole register shifts left by 1.
  - Decrement the counter.
- Completion, on the edge performing the 14th iteration:
  - bcd ← upper 16 bits of the result, or 16'h9999 if overflow_pending.
  - overflow ← overflow_pending; done=1 for exactly that one cycle; busy=0; go to IDLE.
- Latency:
  - Start accepted at edge N → done/bcd valid after edge N+14.
  - Next start can be accepted at edge N+15 (the cycle done is high, since busy=0).
- start while busy=1 is ignored; binary changes while busy do not affect the running conversion.
- bcd and overflow hold their values until the next done or reset.
- done is never asserted without a preceding accepted start.
- Pure unsigned; no sign handling. Every output nibble is always 0–9.

Test Plan:
- Reset: rst_n=0 mid-conversion (start with binary=1234, assert reset after 5 cycles) → busy=0, done=0, bcd=16'h0000 immediately; no done follows.
- Small values, one start each, wait for done:
  - 0 → bcd=16'h0000
  - 10 → 16'h0010
  - 15 → 16'h0015
  - 20 → 16'h0020
  - overflow=0 in all cases.
- Three-digit values:
  - 100 → 16'h0100
  - 125 → 16'h0125
  - 150 → 16'h0150
  - 175 → 16'h0175
  - 200 → 16'h0200
  - 210 → 16'h0210
  - 255 → 16'h0255
  - Check done arrives exactly 14 cycles after the accepting edge.
- Four-digit values:
  - 1150 → 16'h1150
  - 1175 → 16'h1175
  - 1200 → 16'h1200
  - 1210 → 16'h1210
  - 1255 → 16'h1255
  - 9999 → 16'h9999 with overflow=0.
- Overflow: 10000 and 16383 → bcd=16'h9999, overflow=1.
- Handshake:
  - Pulse start with 42, then pulse start with 77 three cycles later → second start ignored; result 16'h0042.
  - Start 77 in the done cycle → accepted; 16'h0077 after 14 more cycles.
